// File: rtl/kv_cache.sv
// kv_cache: valid-gated key/value vector store with one-cycle registered read.
// Define KV_CACHE_BYPASS_EN to forward a same-cycle write to the read port.
module kv_cache #(
    parameter int MAX_SEQ_LEN = 8,
    parameter int HEAD_DIM = 12,
    parameter int DW = 4,
    localparam int AW = $clog2(MAX_SEQ_LEN),
    localparam int W = HEAD_DIM * DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write_en,
    input  logic [AW-1:0] write_addr,
    input  logic [W-1:0]  data_in,
    input  logic [AW-1:0] read_addr,
    output logic [W-1:0]  data_out,
    output logic          valid_out
);
    logic [W-1:0]           mem [MAX_SEQ_LEN];
    logic [MAX_SEQ_LEN-1:0] valid;
    logic                   nxt_valid;
    logic [W-1:0]           nxt_data;

    // The array itself is never reset; valid bits alone decide visibility.
    always_ff @(posedge clk)
        if (write_en && !rst) mem[write_addr] <= data_in;

`ifdef KV_CACHE_BYPASS_EN
    logic hit;
    assign hit       = write_en && (write_addr == read_addr);
    assign nxt_valid = hit | valid[read_addr];
    assign nxt_data  = hit ? data_in : (valid[read_addr] ? mem[read_addr] : '0);
`else
    assign nxt_valid = valid[read_addr];
    assign nxt_data  = valid[read_addr] ? mem[read_addr] : '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            if (write_en) valid[write_addr] <= 1'b1;
            data_out  <= nxt_data;
            valid_out <= nxt_valid;
        end
    end
endmodule

// File: tb/tb_kv_cache.sv
// tb_kv_cache: random and directed stimulus against an array-based reference model.
module tb_kv_cache;
    localparam int N = 8;
    localparam int HD = 12;
    localparam int DW = 4;
    localparam int AW = $clog2(N);
    localparam int W = HD * DW;

    logic          clk = 0;
    logic          rst = 1;
    logic          write_en = 0;
    logic [AW-1:0] write_addr = '0;
    logic [W-1:0]  data_in = '0;
    logic [AW-1:0] read_addr = '0;
    logic [W-1:0]  data_out;
    logic          valid_out;

    int errs = 0;
    int checks = 0;
    bit chk_on = 0;

    logic [W-1:0] m_mem [N];
    logic         m_valid [N];
    logic [W-1:0] exp_data;
    logic         exp_valid;

    kv_cache #(.MAX_SEQ_LEN(N), .HEAD_DIM(HD), .DW(DW)) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .write_addr(write_addr),
        .data_in(data_in), .read_addr(read_addr), .data_out(data_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    // Reference: a read sees the state before this edge's write.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m_valid[i] <= 1'b0;
            exp_data  <= '0;
            exp_valid <= 1'b0;
        end else begin
            exp_valid <= m_valid[read_addr];
            exp_data  <= m_valid[read_addr] ? m_mem[read_addr] : '0;
`ifdef KV_CACHE_BYPASS_EN
            if (write_en && write_addr == read_addr) begin
                exp_valid <= 1'b1;
                exp_data  <= data_in;
            end
`endif
            if (write_en) begin
                m_mem[write_addr]   <= data_in;
                m_valid[write_addr] <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_valid", W'(valid_out), W'(exp_valid));
            chk("model_data", data_out, exp_data);
        end
    end

    function automatic logic [W-1:0] vec(int base, int a);
        logic [W-1:0] v = '0;
        for (int h = 0; h < HD; h++) v[W-1-h*DW -: DW] = DW'(base + a * 10 + h);
        return v;
    endfunction

    task automatic wr(input int a, input logic [W-1:0] d);
        @(negedge clk);
        write_en = 1; write_addr = AW'(a); data_in = d;
    endtask

    task automatic rd(input string name, input int a, input logic v, input logic [W-1:0] d);
        @(negedge clk);
        write_en = 0; read_addr = AW'(a);
        @(negedge clk);
        chk({name, "_v"}, W'(valid_out), W'(v));
        chk({name, "_d"}, data_out, d);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        write_en = 0; rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk_on = 1;
        for (int a = 0; a < N; a++) rd("empty", a, 0, '0);

        for (int a = 0; a < N; a++) wr(a, vec(0, a));
        for (int a = 0; a < N; a++) rd("fill", a, 1, vec(0, a));
        rd("fill1_lit", 1, 1, 48'hABCDEF012345);

        wr(3, vec(100, 0));
        rd("ovw3_lit", 3, 1, 48'h456789ABCDEF);
        rd("keep2", 2, 1, vec(0, 2));
        rd("keep4", 4, 1, vec(0, 4));

        pulse_rst();
        @(negedge clk);
        write_en = 1; write_addr = 5; read_addr = 5; data_in = 48'h0123456789AB;
        @(negedge clk);
        write_en = 0;
`ifdef KV_CACHE_BYPASS_EN
        chk("same5_v", W'(valid_out), W'(1));
        chk("same5_d", data_out, 48'h0123456789AB);
`else
        chk("same5_v", W'(valid_out), W'(0));
        chk("same5_d", data_out, '0);
`endif
        rd("after5", 5, 1, 48'h0123456789AB);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            write_en   = 1'($urandom_range(0, 1));
            write_addr = AW'($urandom_range(0, N - 1));
            read_addr  = AW'($urandom_range(0, N - 1));
            data_in    = {$urandom, $urandom};
        end

        for (int a = 0; a < N; a++) wr(a, vec(7, a));
        rd("prerst", 6, 1, vec(7, 6));
        #2 rst = 1;
        #1;
        chk("async_v", W'(valid_out), W'(0));
        chk("async_d", data_out, '0);
        @(negedge clk);
        rst = 0;
        for (int a = 0; a < N; a++) rd("postrst", a, 0, '0);

        @(negedge clk);
        rst = 1; write_en = 1; write_addr = 0; data_in = 48'hFFFFFFFFFFFF;
        @(negedge clk);
        rst = 0; write_en = 0;
        rd("wr_in_rst", 0, 0, '0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/kv_cache.md
KV_CACHE -- requirements
Module: kv_cache

Interface
- REQ-001 SHALL have parameter MAX_SEQ_LEN, default 8: number of cache entries (sequence positions); power of two, >=2.
- REQ-002 SHALL have parameter HEAD_DIM, default 12: elements per entry vector.
- REQ-003 SHALL have parameter DW, default 4: bits per element.
- REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
- REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
- REQ-006 SHALL have port write_en, input, 1: write strobe, sampled at rising clk.
- REQ-007 SHALL have port write_addr, input, $clog2(MAX_SEQ_LEN): entry index to write.
- REQ-008 SHALL have port data_in, input, HEAD_DIM*DW: vector to write; element 0 in MSBs, element HEAD_DIM-1 in LSBs.
- REQ-009 SHALL have port read_addr, input, $clog2(MAX_SEQ_LEN): entry index to read.
- REQ-010 SHALL have port data_out, output, HEAD_DIM*DW: registered read data, same packing as data_in.
- REQ-011 SHALL have port valid_out, output, 1: registered flag, 1 when data_out comes from a written entry.

Function
- REQ-012 SHALL store MAX_SEQ_LEN entries of HEAD_DIM*DW bits, each with a valid bit.
- REQ-013 SHALL, on a rising edge with write_en=1, store data_in at write_addr and set that entry's valid bit; an existing entry is overwritten in full.
- REQ-014 SHALL, on every rising edge (no enable), register data_out <= mem[read_addr] and valid_out <= valid[read_addr]: one-cycle read latency.
- REQ-015 SHALL drive data_out to all zeros when the addressed entry's valid bit is 0, regardless of array contents.
- REQ-016 SHALL, with write_en=0, leave the array and valid bits unchanged.
- REQ-017 SHALL treat data_in as opaque bits; no arithmetic, no element reordering.
- REQ-018 SHALL, when write and read target the same address in the same cycle, return the pre-write (old) contents and old valid bit unless KV_CACHE_BYPASS_EN is defined (REQ-023).
- REQ-019 SHALL accept back-to-back writes every cycle to any addresses, including the same address repeatedly (last write wins).

Reset
- REQ-020 SHALL, while rst=1 (asynchronously, no clock needed), clear all valid bits, data_out to 0 and valid_out to 0.
- REQ-021 SHALL ignore write_en while rst=1; a write coinciding with reset is discarded.
- REQ-022 SHALL need no reset of the data array (valid bits gate visibility); after reset deassertion, first read returns valid_out=0, data_out=0 for every address.

Configuration
- REQ-023 SHALL, when macro KV_CACHE_BYPASS_EN is defined, forward write-to-read: if write_en=1 and write_addr==read_addr in the same cycle, register data_out <= data_in and valid_out <= 1 at that edge; without the macro, REQ-018 old-data behaviour applies.

Verification
- REQ-024 SHALL cover: reset, then read addresses 0..7 with no writes -> valid_out=0, data_out=0 one cycle after each read_addr.
- REQ-025 SHALL cover: write addr a (0..7) with element h = (a*10+h) truncated to DW bits, then read each -> valid_out=1, data_out equals written vector after one cycle.
- REQ-026 SHALL cover: overwrite addr 3 with elements 100+h (truncated), read addr 3 -> new vector, valid_out=1; addrs 2 and 4 unchanged.
- REQ-027 SHALL cover: same-cycle write/read addr 5 (previously unwritten after reset) -> valid_out=0, data_out=0 without KV_CACHE_BYPASS_EN; valid_out=1, data_out=data_in with it.
- REQ-028 SHALL cover: assert rst mid-run after filling all entries, between clock edges -> valid_out and data_out go 0 immediately; all reads after release return valid_out=0.
- REQ-029 SHALL cover: write_en=1 while rst=1 to addr 0 -> after release, read addr 0 returns valid_out=0.
